// File: rtl/pll_cfg_pkg.sv
// Shared types and helpers for the PLLVR dynamic-configuration sequencer.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        RST_ASSERT,
        WAIT_LOCK,
        STABLE_CHK,
        LOCKED,
        FAIL
    } pll_state_t;

    // Divider selects are the field subtracted from all-ones.
    localparam logic [5:0] SEL_MAX = 6'h3F;

    // Width of the shared cycle counters: must hold the largest of the three limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the async bit, then re-register it to settle metastability.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// PLLVR reset/divider sequencer: lock qualification, timeout with retries,
// loss-of-lock monitoring and runtime reconfiguration over valid/ready.
module pll_dyn_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         STABLE_CYCLES = 256,
    parameter int         MAX_RETRY     = 3,
    parameter logic [5:0] IDIV_DEF      = 6'd6,
    parameter logic [5:0] FBDIV_DEF     = 6'd12,
    parameter logic [5:0] ODSEL_DEF     = 6'd8
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idiv,
    input  logic [5:0] cfg_fbdiv,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clk_ok,
    output logic       fail,
    output logic [1:0] attempt,
    output logic [7:0] unlock_cnt
);

    localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK edge that sees lock counts as the first stable cycle.
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [1:0]    RETRY_W  = 2'(MAX_RETRY);

    pll_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_tmo;
    logic [5:0]    r_idsel;
    logic [5:0]    r_fbdsel;
    logic [5:0]    r_odsel;
    logic          r_pll_reset;
    logic          r_clk_ok;
    logic          r_fail;
    logic          r_cfg_ready;
    logic [1:0]    r_attempt;
    logic [7:0]    r_unlock_cnt;
    logic          w_lock_s;
    logic          w_hs;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .i_clk (clkin),
        .i_rst (reset),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    // Ready is only ever high in LOCKED or FAIL, so this is the whole handshake.
    assign w_hs = cfg_valid && r_cfg_ready;

    // Divider selects reload only on a handshake, which also raises pll_reset.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_idsel  <= SEL_MAX - IDIV_DEF;
            r_fbdsel <= SEL_MAX - FBDIV_DEF;
            r_odsel  <= ODSEL_DEF;
        end else if (w_hs) begin
            r_idsel  <= SEL_MAX - cfg_idiv;
            r_fbdsel <= SEL_MAX - cfg_fbdiv;
            r_odsel  <= cfg_odsel;
        end
    end

    // Sequencer: reset pulse, lock wait with timeout, stability window, monitoring.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state      <= RST_ASSERT;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_pll_reset  <= 1'b1;
            r_clk_ok     <= 1'b0;
            r_fail       <= 1'b0;
            r_cfg_ready  <= 1'b0;
            r_attempt    <= '0;
            r_unlock_cnt <= '0;
        end else begin
            case (r_state)
                RST_ASSERT: begin
                    r_pll_reset <= 1'b1;
                    if (r_cnt == RST_LAST) begin
                        r_pll_reset <= 1'b0;
                        r_cnt       <= '0;
                        r_tmo       <= '0;
                        r_state     <= WAIT_LOCK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (r_tmo != TMO_LAST) r_tmo <= r_tmo + 1'b1;
                    if (w_lock_s) begin
                        r_cnt   <= '0;
                        r_state <= STABLE_CHK;
                    end else if (r_tmo == TMO_LAST) begin
                        r_pll_reset <= 1'b1;
                        r_cnt       <= '0;
                        if (r_attempt < RETRY_W) begin
                            r_attempt <= r_attempt + 1'b1;
                            r_state   <= RST_ASSERT;
                        end else begin
                            r_fail      <= 1'b1;
                            r_cfg_ready <= 1'b1;
                            r_state     <= FAIL;
                        end
                    end
                end
                STABLE_CHK: begin
                    // Timeout keeps running so lock chatter cannot extend the attempt.
                    if (r_tmo != TMO_LAST) r_tmo <= r_tmo + 1'b1;
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_cnt == STB_LAST) begin
                        r_clk_ok    <= 1'b1;
                        r_cfg_ready <= 1'b1;
                        r_state     <= LOCKED;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_lock_s && r_unlock_cnt != 8'hFF)
                        r_unlock_cnt <= r_unlock_cnt + 1'b1;
                    if (w_hs || !w_lock_s) begin
                        r_clk_ok    <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        r_attempt   <= '0;
                        r_pll_reset <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= RST_ASSERT;
                    end
                end
                FAIL: begin
                    if (w_hs) begin
                        r_fail      <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        r_attempt   <= '0;
                        r_cnt       <= '0;
                        r_state     <= RST_ASSERT;
                    end
                end
                default: r_state <= RST_ASSERT;
            endcase
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign pll_reset  = r_pll_reset;
    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;
    assign clk_ok     = r_clk_ok;
    assign fail       = r_fail;
    assign attempt    = r_attempt;
    assign unlock_cnt = r_unlock_cnt;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: behavioural lock-sequence model checked every
// cycle, plus directed scenarios with hand-computed timing expectations.
module tb_pll_dyn_cfg_ctrl;

    localparam int RSTC = 16;
    localparam int TMO  = 200;
    localparam int STB  = 256;
    localparam int MAXR = 3;

    logic       clkin = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idiv, cfg_fbdiv, cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       clk_ok, fail;
    logic [1:0] attempt;
    logic [7:0] unlock_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon    = 1'b0;

    int lock_delay  = 100;  // cycles after pll_reset falls before the PLL locks; <0 = never
    int glitch_left = 0;    // cycles to force LOCK low

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STB),
        .MAX_RETRY    (MAXR),
        .IDIV_DEF     (6'd6),
        .FBDIV_DEF    (6'd12),
        .ODSEL_DEF    (6'd8)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idiv   (cfg_idiv),
        .cfg_fbdiv  (cfg_fbdiv),
        .cfg_odsel  (cfg_odsel),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .clk_ok     (clk_ok),
        .fail       (fail),
        .attempt    (attempt),
        .unlock_cnt (unlock_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // PLL stand-in: locks lock_delay cycles after its reset is released.
    initial begin
        int  c;
        bit  lk;
        c = 0;
        lk = 1'b0;
        pll_lock = 1'b0;
        forever begin
            @(posedge clkin); #1;
            if (reset || pll_reset) begin
                c  = 0;
                lk = 1'b0;
            end else begin
                c++;
                if (glitch_left > 0) begin
                    lk = 1'b0;
                    glitch_left--;
                end else begin
                    lk = (lock_delay >= 0) && (c > lock_delay);
                end
            end
            pll_lock = lk;
        end
    end

    // Model: phase 0 reset pulse, 1 waiting for qualified lock, 2 locked, 3 failed.
    int         m_ph, m_left, m_e, m_run, m_att, m_unl;
    bit         m_prevL, m_s1, m_s2;
    logic [5:0] m_idiv, m_fbdiv, m_odsel;

    always @(posedge clkin or posedge reset) begin
        bit L, hs;
        if (reset) begin
            m_ph = 0; m_left = RSTC; m_att = 0; m_unl = 0;
            m_s1 = 0; m_s2 = 0;
            m_idiv = 6'd6; m_fbdiv = 6'd12; m_odsel = 6'd8;
        end else begin
            L = m_s2; m_s2 = m_s1; m_s1 = pll_lock;   // LOCK seen two cycles late
            hs = cfg_valid && (m_ph >= 2);
            case (m_ph)
                0: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = 1; m_e = 0; m_run = 0; m_prevL = 0; end
                end
                1: begin
                    m_e++;
                    m_run = L ? m_run + 1 : 0;
                    if (m_run == STB) m_ph = 2;
                    else if (!L && !m_prevL && m_e >= TMO) begin
                        if (m_att < MAXR) begin m_att++; m_ph = 0; m_left = RSTC; end
                        else m_ph = 3;
                    end
                    m_prevL = L;
                end
                2: begin
                    if (!L && m_unl < 255) m_unl++;
                    if (hs || !L) begin m_att = 0; m_ph = 0; m_left = RSTC; end
                end
                default: begin
                    if (hs) begin m_att = 0; m_ph = 0; m_left = RSTC; end
                end
            endcase
            if (hs) begin m_idiv = cfg_idiv; m_fbdiv = cfg_fbdiv; m_odsel = cfg_odsel; end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clkin) begin
        logic [31:0] act, exp;
        if (mon) begin
            act = {pll_reset, clk_ok, fail, cfg_ready, attempt, unlock_cnt,
                   pll_idsel, pll_fbdsel, pll_odsel};
            exp = {(m_ph == 0 || m_ph == 3), (m_ph == 2), (m_ph == 3), (m_ph >= 2),
                   m_att[1:0], m_unl[7:0], 6'h3F - m_idiv, 6'h3F - m_fbdiv, m_odsel};
            n_chk++;
            if (act == exp) n_pass++;
            else $display("FAIL model_cmp t=%0t: got %08h expected %08h", $time, act, exp);
        end
    end

    function automatic bit sig(input int w);
        case (w)
            0: return pll_reset;
            1: return clk_ok;
            2: return pll_lock;
            default: return 1'b0;
        endcase
    endfunction

    // Count edges until the selected signal reaches v; expiry counts as a failure.
    task automatic wait_for(input string name, input int w, input bit v, input int budget,
                            output int n);
        n = 0;
        while (sig(w) !== v && n < budget) begin
            @(posedge clkin); #2;
            n++;
        end
        if (sig(w) !== v) begin
            n_chk++;
            $display("FAIL %s: timeout after %0d cycles", name, n);
        end
    endtask

    task automatic do_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        int n;
        bit hit;
        n = 0;
        @(posedge clkin); #1;
        cfg_idiv = i; cfg_fbdiv = f; cfg_odsel = o; cfg_valid = 1'b1;
        do begin
            @(posedge clkin);
            hit = cfg_ready;
            n++;
        end while (!hit && n < 1000);
        #1 cfg_valid = 1'b0;
        if (!hit) begin
            n_chk++;
            $display("FAIL handshake: no ready after %0d cycles", n);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; cfg_valid = 1'b0;
        cfg_idiv = '0; cfg_fbdiv = '0; cfg_odsel = '0;
        repeat (3) @(posedge clkin);
        #2;
        mon = 1'b1;
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_clk_ok", clk_ok, 0);
        chk("rst_fail", fail, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_attempt", attempt, 0);
        chk("rst_unlock", unlock_cnt, 0);
        chk("rst_idsel", pll_idsel, 'h39);
        chk("rst_fbdsel", pll_fbdsel, 'h33);
        chk("rst_odsel", pll_odsel, 8);
        reset = 1'b0;

        // Power-up: 16-cycle reset pulse, lock 100 cycles later, 2 sync + 256 stable.
        wait_for("pwr_rst_fall", 0, 0, 100, n);
        chk("pwr_rst_len", n, 16);
        wait_for("pwr_clk_ok", 1, 1, 1000, n);
        chk("pwr_clk_ok_delay", n, 358);
        chk("pwr_idsel", pll_idsel, 'h39);
        chk("pwr_fbdsel", pll_fbdsel, 'h33);

        // Reconfigure from LOCKED.
        do_cfg(6'd3, 6'd20, 6'd4);
        chk("cfg_ready_drop", cfg_ready, 0);
        chk("cfg_pll_reset", pll_reset, 1);
        chk("cfg_clk_ok", clk_ok, 0);
        chk("cfg_idsel", pll_idsel, 'h3C);
        chk("cfg_fbdsel", pll_fbdsel, 'h2B);
        chk("cfg_odsel", pll_odsel, 4);
        wait_for("cfg_relock", 1, 1, 600, n);

        // Three loss-of-lock events in LOCKED.
        for (int k = 0; k < 3; k++) begin
            glitch_left = 1;
            wait_for("drop_rst", 0, 1, 20, n);
            chk("drop_clk_ok", clk_ok, 0);
            chk("drop_attempt", attempt, 0);
            wait_for("drop_relock", 1, 1, 600, n);
        end
        chk("drop_unlock_cnt", unlock_cnt, 3);

        // One-cycle glitch mid-window: a fresh 256-cycle window is required.
        do_cfg(6'd6, 6'd12, 6'd8);
        chk("def_idsel", pll_idsel, 'h39);
        wait_for("g1_lock", 2, 1, 200, n);
        repeat (100) begin @(posedge clkin); #2; end
        glitch_left = 1;
        wait_for("g1_low", 2, 0, 5, n);
        @(posedge clkin); #2;
        chk("g1_lock_back", pll_lock, 1);
        wait_for("g1_clk_ok", 1, 1, 600, n);
        chk("g1_clk_ok_delay", n, 258);
        chk("g1_attempt", attempt, 0);
        chk("g1_unlock_cnt", unlock_cnt, 3);

        // Two-cycle glitch after the timeout has run out: attempt fails at once.
        do_cfg(6'd6, 6'd12, 6'd8);
        wait_for("g2_lock", 2, 1, 200, n);
        repeat (150) begin @(posedge clkin); #2; end
        glitch_left = 2;
        wait_for("g2_rst", 0, 1, 20, n);
        chk("g2_attempt", attempt, 1);
        wait_for("g2_relock", 1, 1, 600, n);

        // Lock never arrives: four attempts then FAIL.
        do_cfg(6'd6, 6'd12, 6'd8);
        #1 lock_delay = -1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo_attempt_%0d", k), attempt, k);
            wait_for("tmo_rst_fall", 0, 0, 100, n);
            wait_for("tmo_rst_rise", 0, 1, 400, n);
            chk($sformatf("tmo_wait_len_%0d", k), n, TMO);
        end
        repeat (20) begin @(posedge clkin); #2; end
        chk("fail_flag", fail, 1);
        chk("fail_pll_reset", pll_reset, 1);
        chk("fail_ready", cfg_ready, 1);
        chk("fail_attempt", attempt, 3);

        // Leave FAIL through a handshake, then reset mid stability check.
        lock_delay = 100;
        do_cfg(6'd3, 6'd20, 6'd4);
        chk("unfail_flag", fail, 0);
        chk("unfail_pll_reset", pll_reset, 1);
        chk("unfail_idsel", pll_idsel, 'h3C);
        wait_for("ar_lock", 2, 1, 200, n);
        repeat (50) begin @(posedge clkin); #2; end
        @(posedge clkin); #3;
        reset = 1'b1;
        #1;
        chk("ar_pll_reset", pll_reset, 1);
        chk("ar_clk_ok", clk_ok, 0);
        chk("ar_ready", cfg_ready, 0);
        chk("ar_unlock", unlock_cnt, 0);
        chk("ar_idsel", pll_idsel, 'h39);
        chk("ar_fbdsel", pll_fbdsel, 'h33);
        chk("ar_odsel", pll_odsel, 8);
        @(posedge clkin); #2;
        reset = 1'b0;
        wait_for("ar_relock", 1, 1, 600, n);
        chk("ar_final_attempt", attempt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_dyn_cfg_ctrl.md
Name: pll_dyn_cfg_ctrl

Overview:
Sequencer for the PLLVR instance in the frequency-measurement design. It owns the PLL reset and the dynamic divider selects (IDSEL/FBDSEL/ODSEL), and accepts runtime reconfiguration requests over a valid/ready handshake. It qualifies LOCK with a stability window, applies a timeout with bounded retries, and monitors for loss of lock. Downstream logic enables on clk_ok. The block runs on the PLL reference clock (27 MHz), never on the PLL output.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=2)
LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before the attempt fails
STABLE_CYCLES, 256, consecutive synced-lock cycles required to declare lock
MAX_RETRY, 3, reset attempts after the first before entering FAIL
IDIV_DEF, 6, divider field loaded at reset
FBDIV_DEF, 12, divider field loaded at reset
ODSEL_DEF, 6'd8, output-divider code loaded at reset

Ports:
clkin  in  1  reference clock, 27 MHz
reset  in  1  asynchronous, active-high
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  high only in LOCKED or FAIL; transfer when valid&&ready
cfg_idiv  in  6  input-divider field
cfg_fbdiv  in  6  feedback-divider field
cfg_odsel  in  6  output-divider code, passed through unencoded
pll_lock  in  1  PLLVR LOCK, asynchronous to clkin
pll_reset  out  1  to PLLVR RESET
pll_idsel  out  6  to IDSEL, equals 6'h3F - idiv_r
pll_fbdsel  out  6  to FBDSEL, equals 6'h3F - fbdiv_r
pll_odsel  out  6  to ODSEL, equals odsel_r
clk_ok  out  1  PLL output qualified stable
fail  out  1  retries exhausted
attempt  out  2  attempts used in the current sequence
unlock_cnt  out  8  lock-loss events since reset, saturating at 255

Behaviour:
- Lock synchronisation: pll_lock passes through a 2-flop synchroniser, giving lock_s. Only lock_s is used. This adds 2 cycles of latency.
- Register reset values:
  - idiv_r=IDIV_DEF, fbdiv_r=FBDIV_DEF, odsel_r=ODSEL_DEF.
  - pll_reset=1, clk_ok=0, fail=0, cfg_ready=0, attempt=0, unlock_cnt=0.
  - state=RST_ASSERT, cnt=0.
- Divider outputs: all selects are registered. They change only on a handshake, and only while pll_reset is high. A handshake forces pll_reset high in the same edge.
- RST_ASSERT: pll_reset=1. cnt counts to RST_CYCLES-1, then pll_reset=0, cnt=0, go to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1: go to STABLE_CHK, cnt=0.
  - cnt reaches LOCK_TIMEOUT with no lock: this is an attempt failure.
- STABLE_CHK:
  - lock_s=0: go back to WAIT_LOCK. The timeout counter is not cleared and continues counting.
  - lock_s=1 for STABLE_CYCLES consecutive cycles: go to LOCKED, clk_ok=1, cfg_ready=1.
- Attempt failure: if attempt<MAX_RETRY, increment attempt and go to RST_ASSERT. Otherwise go to FAIL: fail=1, pll_reset=1, cfg_ready=1.
- LOCKED:
  - lock_s falls: clk_ok=0 on the next edge, unlock_cnt+1 (saturating), attempt=0, go to RST_ASSERT.
  - Handshake: latch the cfg fields, clk_ok=0, attempt=0, go to RST_ASSERT.
- FAIL: holds until a handshake arrives or reset asserts. A handshake clears fail, latches the fields and goes to RST_ASSERT.
- Simultaneous events: if lock is lost in LOCKED in the same cycle as a handshake, the handshake wins and the new config is latched. unlock_cnt is still incremented.
- cfg_valid outside LOCKED/FAIL: ignored (no ready); the requester holds it.
- Reset mid-sequence: counters clear and the defaults reload immediately; pll_reset goes high asynchronously.
- clk_ok timing: deasserts within 1 clkin edge after lock_s falls, i.e. at most 3 edges after pll_lock falls.

Decomposition:
- Package pll_cfg_pkg holds:
  - state enum (RST_ASSERT, WAIT_LOCK, STABLE_CHK, LOCKED, FAIL);
  - counter width function clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES));
  - SEL_MAX=6'h3F.
- One sub-module, sync_2ff: a generic bit synchroniser, reused elsewhere for async inputs.

Test Plan:
- Power-up with lock model asserting 100 cycles after pll_reset falls -> pll_reset high for exactly 16 cycles; clk_ok rises 100+2+256 cycles after pll_reset falls; pll_idsel=6'h39, pll_fbdsel=6'h33.
- In LOCKED, cfg_valid with idiv=3, fbdiv=20, odsel=4 -> cfg_ready high and a one-cycle transfer; pll_reset=1 and clk_ok=0 next edge; pll_idsel=6'h3C, pll_fbdsel=6'h2B, pll_odsel=4 while reset is held; relock follows.
- Lock never asserts (LOCK_TIMEOUT reduced to 200 in the bench) -> 4 reset pulses with attempt=0,1,2,3; then fail=1, pll_reset stays high, cfg_ready=1.
- Lock glitch low for 1 cycle at stable count 100 -> back to WAIT_LOCK; clk_ok only after a fresh 256-cycle window; the timeout counter is not restarted.
- Lock drops in LOCKED three times -> unlock_cnt=3, each drop followed by a full reset sequence, attempt=0.
- Assert reset during STABLE_CHK with non-default config latched -> all outputs return to their reset values asynchronously; default selects restored.
